// File: rtl/note_glyph_pkg.sv
// Shared types, note codes and 12x12 bitmaps for the note label drawer.
// Each bitmap is row-major with row 0 in the MSBs and column 0 as the MSB of a row.
package note_glyph_pkg;
  localparam int GLYPH_BITS = 144;
  typedef logic [GLYPH_BITS-1:0] glyph_t;

  typedef enum logic [2:0] {ST_IDLE, ST_SHARP, ST_LETTER, ST_OCTAVE, ST_CLEAR, ST_DONE} state_t;

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] octave;
  } label_t;

  localparam logic [3:0] NOTE_A  = 4'd1,  NOTE_AS = 4'd2,  NOTE_B  = 4'd3,
                         NOTE_C  = 4'd4,  NOTE_CS = 4'd5,  NOTE_D  = 4'd6,
                         NOTE_DS = 4'd7,  NOTE_E  = 4'd8,  NOTE_F  = 4'd9,
                         NOTE_FS = 4'd10, NOTE_G  = 4'd11, NOTE_GS = 4'd12;

  localparam glyph_t GLYPH_BLANK = '0;
  localparam glyph_t GLYPH_SHARP = {
    12'b000000000000, 12'b001000100000, 12'b001000100000, 12'b111111111100,
    12'b001000100000, 12'b001000100000, 12'b001000100000, 12'b111111111100,
    12'b001000100000, 12'b001000100000, 12'b001000100000, 12'b000000000000};
  localparam glyph_t GLYPH_A = {
    12'b000000000000, 12'b000001100000, 12'b000010010000, 12'b000100001000,
    12'b001000000100, 12'b001000000100, 12'b001111111100, 12'b001000000100,
    12'b001000000100, 12'b001000000100, 12'b001000000100, 12'b000000000000};
  localparam glyph_t GLYPH_B = {
    12'b000000000000, 12'b011111110000, 12'b010000001000, 12'b010000001000,
    12'b010000001000, 12'b011111110000, 12'b010000001000, 12'b010000000100,
    12'b010000000100, 12'b010000001000, 12'b011111110000, 12'b000000000000};
  localparam glyph_t GLYPH_C = {
    12'b000000000000, 12'b011111111100, 12'b010000000000, 12'b010000000000,
    12'b010000000000, 12'b010000000000, 12'b010000000000, 12'b010000000000,
    12'b010000000000, 12'b010000000000, 12'b011111111100, 12'b000000000000};
  localparam glyph_t GLYPH_D = {
    12'b000000000000, 12'b011111100000, 12'b010000010000, 12'b010000001000,
    12'b010000000100, 12'b010000000100, 12'b010000000100, 12'b010000000100,
    12'b010000001000, 12'b010000010000, 12'b011111100000, 12'b000000000000};
  localparam glyph_t GLYPH_E = {
    12'b000000000000, 12'b011111111100, 12'b010000000000, 12'b010000000000,
    12'b010000000000, 12'b011111110000, 12'b010000000000, 12'b010000000000,
    12'b010000000000, 12'b010000000000, 12'b011111111100, 12'b000000000000};
  localparam glyph_t GLYPH_F = {
    12'b000000000000, 12'b011111111100, 12'b010000000000, 12'b010000000000,
    12'b010000000000, 12'b011111110000, 12'b010000000000, 12'b010000000000,
    12'b010000000000, 12'b010000000000, 12'b010000000000, 12'b000000000000};
  localparam glyph_t GLYPH_G = {
    12'b000000000000, 12'b001111111000, 12'b010000000100, 12'b010000000000,
    12'b010000000000, 12'b010000111100, 12'b010000000100, 12'b010000000100,
    12'b010000000100, 12'b010000000100, 12'b001111111000, 12'b000000000000};
  localparam glyph_t GLYPH_DIGIT1 = {
    12'b000000000000, 12'b000011000000, 12'b000111000000, 12'b001011000000,
    12'b000011000000, 12'b000011000000, 12'b000011000000, 12'b000011000000,
    12'b000011000000, 12'b000011000000, 12'b001111110000, 12'b000000000000};
  localparam glyph_t GLYPH_DIGIT2 = {
    12'b000000000000, 12'b001111110000, 12'b010000001000, 12'b000000001000,
    12'b000000010000, 12'b000000100000, 12'b000001000000, 12'b000010000000,
    12'b000100000000, 12'b001000000000, 12'b011111111000, 12'b000000000000};
  localparam glyph_t GLYPH_DIGIT3 = {
    12'b000000000000, 12'b011111110000, 12'b000000001000, 12'b000000001000,
    12'b000000010000, 12'b000111100000, 12'b000000010000, 12'b000000001000,
    12'b000000001000, 12'b000000001000, 12'b011111110000, 12'b000000000000};
  localparam glyph_t GLYPH_DIGIT4 = {
    12'b000000000000, 12'b000000110000, 12'b000001010000, 12'b000010010000,
    12'b000100010000, 12'b001000010000, 12'b010000010000, 12'b011111111100,
    12'b000000010000, 12'b000000010000, 12'b000000010000, 12'b000000000000};
endpackage

// File: rtl/note_glyph_rom.sv
// Maps a latched (note, octave) label to its letter, sharp and octave-digit bitmaps.
module note_glyph_rom
  import note_glyph_pkg::*;
(
  input  logic [3:0] note,
  input  logic [1:0] octave,
  output glyph_t     letter,
  output glyph_t     sharp,
  output glyph_t     oct
);
  // Invalid note codes leave both letter and sharp blank.
  always_comb begin
    letter = GLYPH_BLANK;
    sharp  = GLYPH_BLANK;
    case (note)
      NOTE_A:  letter = GLYPH_A;
      NOTE_AS: begin letter = GLYPH_A; sharp = GLYPH_SHARP; end
      NOTE_B:  letter = GLYPH_B;
      NOTE_C:  letter = GLYPH_C;
      NOTE_CS: begin letter = GLYPH_C; sharp = GLYPH_SHARP; end
      NOTE_D:  letter = GLYPH_D;
      NOTE_DS: begin letter = GLYPH_D; sharp = GLYPH_SHARP; end
      NOTE_E:  letter = GLYPH_E;
      NOTE_F:  letter = GLYPH_F;
      NOTE_FS: begin letter = GLYPH_F; sharp = GLYPH_SHARP; end
      NOTE_G:  letter = GLYPH_G;
      NOTE_GS: begin letter = GLYPH_G; sharp = GLYPH_SHARP; end
      default: ;
    endcase
  end

  always_comb begin
    oct = GLYPH_DIGIT1;
    case (octave)
      2'd0: oct = GLYPH_DIGIT1;
      2'd1: oct = GLYPH_DIGIT2;
      2'd2: oct = GLYPH_DIGIT3;
      2'd3: oct = GLYPH_DIGIT4;
    endcase
  end
endmodule

// File: rtl/note_glyph_drawer.sv
// Draws a sharp/letter/octave label (or clears the screen) one pixel per clock
// into the VGA adapter's x/y/colour/plot interface, clipping off-screen pixels.
module note_glyph_drawer
  import note_glyph_pkg::*;
#(
  parameter int         GLYPH_W   = 12,
  parameter int         GLYPH_H   = 12,
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] FG_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           clear_req,
  input  logic [3:0]     note,
  input  logic [1:0]     octave,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     colour,
  output logic           writeEn
);
  localparam int NB  = GLYPH_W * GLYPH_H;
  localparam int IW  = $clog2(NB);
  // Wide enough that the clip test sees the coordinate before truncation.
  localparam int UXW = X_W + $clog2(3 * GLYPH_W) + 1;
  localparam int UYW = Y_W + $clog2(GLYPH_H) + 1;

  state_t         state, state_nx;
  label_t         lbl_q;
  logic [X_W-1:0] x_q, col, col_last;
  logic [Y_W-1:0] y_q, row, row_last;
  glyph_t         g_letter, g_sharp, g_oct, g_cur;
  logic [UXW-1:0] x_off, ux;
  logic [UYW-1:0] uy;
  logic [IW-1:0]  pix_idx;
  logic           pix_state, cell_end, pix_vis;
  logic [2:0]     pix_colour;

  note_glyph_rom u_rom (
    .note   (lbl_q.note),
    .octave (lbl_q.octave),
    .letter (g_letter),
    .sharp  (g_sharp),
    .oct    (g_oct)
  );

  always_comb begin
    pix_state = state inside {ST_SHARP, ST_LETTER, ST_OCTAVE, ST_CLEAR};
    col_last  = X_W'(GLYPH_W - 1);
    row_last  = Y_W'(GLYPH_H - 1);
    g_cur     = g_sharp;
    x_off     = '0;
    case (state)
      ST_LETTER: begin g_cur = g_letter; x_off = UXW'(GLYPH_W); end
      ST_OCTAVE: begin g_cur = g_oct;    x_off = UXW'(2 * GLYPH_W); end
      ST_CLEAR:  begin col_last = X_W'(SCREEN_W - 1); row_last = Y_W'(SCREEN_H - 1); end
      default: ;
    endcase
    cell_end = (col == col_last) && (row == row_last);
    pix_idx  = IW'(NB - 1) - (IW'(row) * IW'(GLYPH_W) + IW'(col));
    if (state == ST_CLEAR) begin
      ux         = UXW'(col);
      uy         = UYW'(row);
      pix_colour = BG_COLOUR;
    end else begin
      ux         = UXW'(x_q) + x_off + UXW'(col);
      uy         = UYW'(y_q) + UYW'(row);
      pix_colour = g_cur[pix_idx] ? FG_COLOUR : BG_COLOUR;
    end
    pix_vis = (ux < UXW'(SCREEN_W)) && (uy < UYW'(SCREEN_H));
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (clear_req) state_nx = ST_CLEAR;
                 else if (start) state_nx = ST_SHARP;
      ST_SHARP:  if (cell_end) state_nx = ST_LETTER;
      ST_LETTER: if (cell_end) state_nx = ST_OCTAVE;
      ST_OCTAVE: if (cell_end) state_nx = ST_DONE;
      ST_CLEAR:  if (cell_end) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lbl_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col     <= '0;
      row     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      writeEn <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= '0;
    end else begin
      busy    <= pix_state;
      done    <= (state == ST_DONE);
      writeEn <= 1'b0;
      if (state == ST_IDLE && !clear_req && start) begin
        lbl_q <= '{note: note, octave: octave};
        x_q   <= x;
        y_q   <= y;
      end
      if (pix_state) begin
        x_out   <= X_W'(ux);
        y_out   <= Y_W'(uy);
        colour  <= pix_colour;
        writeEn <= pix_vis;
        // Counters wrap to zero at each cell end, ready for the next cell.
        if (col == col_last) begin
          col <= '0;
          row <= (row == row_last) ? '0 : row + Y_W'(1);
        end else begin
          col <= col + X_W'(1);
        end
      end else begin
        col <= '0;
        row <= '0;
      end
    end
  end
endmodule

// File: tb/tb_note_glyph_drawer.sv
// Vector table of draw/clear requests checked against a pixel scoreboard,
// plus hand-written reset sequences.
module tb_note_glyph_drawer;
  import note_glyph_pkg::*;

  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] BG = 3'b000;
  localparam int BOUND = 25000;

  logic       clk, resetn, start, clear_req;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] x;
  logic [6:0] y;
  logic       busy, done, writeEn;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;

  int n_tests, n_fail;
  logic [17:0] sb[$];
  logic [2:0]  pix_map [256][128];
  logic [17:0] first_w;

  typedef struct {
    logic       clr;
    logic       stt;
    logic [3:0] note;
    logic [1:0] oct;
    logic [7:0] x;
    logic [6:0] y;
    int         pulse_at;
    int         exp_wr;
    int         exp_lat;
  } vec_t;
  vec_t vecs[5];

  note_glyph_drawer dut (
    .clk(clk), .resetn(resetn), .start(start), .clear_req(clear_req),
    .note(note), .octave(octave), .x(x), .y(y),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour(colour), .writeEn(writeEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic glyph_t m_letter(input logic [3:0] n);
    case (n)
      4'd1, 4'd2:   return GLYPH_A;
      4'd3:         return GLYPH_B;
      4'd4, 4'd5:   return GLYPH_C;
      4'd6, 4'd7:   return GLYPH_D;
      4'd8:         return GLYPH_E;
      4'd9, 4'd10:  return GLYPH_F;
      4'd11, 4'd12: return GLYPH_G;
      default:      return GLYPH_BLANK;
    endcase
  endfunction

  function automatic glyph_t m_sharp(input logic [3:0] n);
    return (n inside {4'd2, 4'd5, 4'd7, 4'd10, 4'd12}) ? GLYPH_SHARP : GLYPH_BLANK;
  endfunction

  function automatic glyph_t m_digit(input logic [1:0] o);
    case (o)
      2'd0:    return GLYPH_DIGIT1;
      2'd1:    return GLYPH_DIGIT2;
      2'd2:    return GLYPH_DIGIT3;
      default: return GLYPH_DIGIT4;
    endcase
  endfunction

  task automatic push_expected(input vec_t v);
    glyph_t g [3];
    int ux, uy;
    if (v.clr) begin
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++)
          sb.push_back({8'(xx), 7'(yy), BG});
    end else begin
      g[0] = m_sharp(v.note);
      g[1] = m_letter(v.note);
      g[2] = m_digit(v.oct);
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 12; r++)
          for (int k = 0; k < 12; k++) begin
            ux = int'(v.x) + c * 12 + k;
            uy = int'(v.y) + r;
            if (ux < 160 && uy < 120)
              sb.push_back({8'(ux), 7'(uy), g[c][143 - (r * 12 + k)] ? FG : BG});
          end
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat, wr, perr, cerr;
    logic busy1, busy_done;
    lat = 0; wr = 0; perr = 0; cerr = 0; busy1 = 0; busy_done = 1;
    sb.delete();
    push_expected(v);
    @(negedge clk);
    clear_req = v.clr; start = v.stt; note = v.note; octave = v.oct; x = v.x; y = v.y;
    for (int i = 0; i <= BOUND; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Scramble inputs so a design that fails to latch draws the wrong label.
        start = 0; clear_req = 0; note = 4'd3; octave = 2'd0; x = 8'd200; y = 7'd100;
      end else begin
        start     = (i == v.pulse_at);
        clear_req = (i == v.pulse_at);
      end
      if (writeEn) begin
        if (wr == 0) first_w = {x_out, y_out, colour};
        wr++;
        if (x_out >= 160 || y_out >= 120) cerr++;
        pix_map[x_out][y_out] = colour;
        if (sb.size() == 0) perr++;
        else if (sb.pop_front() != {x_out, y_out, colour}) perr++;
      end
      if (i == 1) busy1 = busy;
      if (done) begin
        lat = i;
        busy_done = busy;
        break;
      end
    end
    start = 0; clear_req = 0;
    @(negedge clk);
    chk("done_latency", lat, v.exp_lat);
    chk("busy_after_accept", busy1, 1);
    chk("busy_at_done", busy_done, 0);
    chk("done_one_cycle", done, 0);
    chk("write_count", wr, v.exp_wr);
    chk("pixels_missing", sb.size(), 0);
    chk("pixel_mismatch", perr, 0);
    chk("clip_violation", cerr, 0);
  endtask

  function automatic int count_fg(input int x0, input int x1, input int y0, input int y1);
    int n = 0;
    for (int i = x0; i <= x1; i++)
      for (int j = y0; j <= y1; j++)
        if (pix_map[i][j] != BG) n++;
    return n;
  endfunction

  initial begin
    int cnt;
    n_tests = 0; n_fail = 0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 128; j++)
        pix_map[i][j] = 3'b111;
    vecs[0] = '{1'b0, 1'b1, 4'd2,  2'd1, 8'd10,  7'd20,  0,   432,   433};
    vecs[1] = '{1'b0, 1'b1, 4'd4,  2'd0, 8'd0,   7'd0,   0,   432,   433};
    vecs[2] = '{1'b0, 1'b1, 4'd5,  2'd3, 8'd150, 7'd115, 0,   50,    433};
    vecs[3] = '{1'b0, 1'b1, 4'd15, 2'd2, 8'd40,  7'd60,  100, 432,   433};
    vecs[4] = '{1'b1, 1'b1, 4'd2,  2'd1, 8'd10,  7'd20,  0,   19200, 19201};

    start = 0; clear_req = 0; note = 0; octave = 0; x = 0; y = 0;
    resetn = 1;
    #1 resetn = 0;
    #1 chk("reset_outputs", {busy, done, writeEn, x_out, y_out, colour}, 0);
    repeat (3) @(negedge clk);
    resetn = 1;

    // Abort a draw of A#/octave 2 part-way through.
    @(negedge clk);
    start = 1; note = 4'd2; octave = 2'd2; x = 8'd10; y = 7'd20;
    @(negedge clk);
    start = 0;
    repeat (50) @(negedge clk);
    chk("busy_mid_draw", busy, 1);
    #2 resetn = 0;
    #1 chk("midrst_outputs", {busy, done, writeEn, x_out, y_out, colour}, 0);
    @(negedge clk);
    resetn = 1;
    cnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (writeEn || busy || done) cnt++;
    end
    chk("idle_after_reset", cnt, 0);

    for (int k = 0; k < 5; k++) begin
      run_op(vecs[k]);
      if (k == 0) begin
        chk("first_write", first_w, {8'd10, 7'd20, BG});
        chk("sharp_px_12_21", pix_map[12][21], FG);
        chk("letter_px_27_21", pix_map[27][21], FG);
      end else if (k == 1) begin
        chk("natural_sharp_blank", count_fg(0, 11, 0, 11), 0);
        chk("letter_px_13_1", pix_map[13][1], FG);
      end else if (k == 3) begin
        chk("invalid_letter_blank", count_fg(52, 63, 60, 71), 0);
      end else if (k == 4) begin
        chk("screen_cleared", count_fg(0, 159, 0, 119), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/note_glyph_drawer.md
Name: note_glyph_drawer

Overview:
- Parametrised successor to the note display path: renders a three-cell label (sharp, letter, octave digit) from bitmap glyphs into the VGA adapter's pixel-write interface.
- Walks every glyph pixel with a proper FSM, writing foreground/background so a redraw erases the previous label.
- Adds full-screen clear, off-screen clipping and a start/busy/done handshake.
- Sits between the note decoder and the VGA adapter's x/y/colour/plot inputs.

Parameters:
- GLYPH_W, 12, glyph width in pixels; also the cell pitch.
- GLYPH_H, 12, glyph height in pixels.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
- FG_COLOUR, 3'b010, colour of set glyph bits.
- BG_COLOUR, 3'b000, colour of clear bits and of screen clear.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  draw request (ld_note); sampled only in IDLE
- clear_req  in  1  full-screen clear request; sampled only in IDLE
- note  in  4  1..12 = A, A#, B, C, C#, D, D#, E, F, F#, G, G#; other codes = blank
- octave  in  2  0..3 displayed as digits 1..4
- x  in  X_W  label origin x (top-left of the sharp cell)
- y  in  Y_W  label origin y
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse after the last pixel
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour  out  3  pixel colour
- writeEn  out  1  pixel write strobe

Behaviour:
- Reset (async, resetn=0): state IDLE. busy, done, writeEn, x_out, y_out and colour are 0. Counters are 0. Reset mid-operation aborts immediately, and no further writes occur.
- States: IDLE, SHARP, LETTER, OCTAVE, CLEAR, DONE.
- IDLE:
  - clear_req=1 -> CLEAR. This has priority if start is also high in the same cycle; that start is dropped.
  - Else start=1 -> latch note, octave, x, y; go to SHARP.
  - start and clear_req are ignored outside IDLE.
- Per glyph state: col 0..GLYPH_W-1 inner, row 0..GLYPH_H-1 outer, one pixel per clk, row-major.
  - Bitmap bit index = GLYPH_W*GLYPH_H-1 - (row*GLYPH_W + col), so the MSB is the top-left pixel.
  - Cell x offsets: SHARP 0, LETTER GLYPH_W, OCTAVE 2*GLYPH_W.
  - x_out = latched x + offset + col, truncated to X_W. y_out = latched y + row, truncated to Y_W.
  - colour = FG_COLOUR if the bit is 1, else BG_COLOUR.
  - writeEn=1 unless the untruncated coordinate is >= SCREEN_W/SCREEN_H. A clipped pixel still consumes its cycle.
- Transitions: SHARP -> LETTER -> OCTAVE -> DONE after the last pixel of each cell.
- Blank glyphs:
  - Natural note: the sharp glyph is all-zero, so the cell is painted BG.
  - Invalid note: the letter glyph is all-zero; the draw proceeds normally.
- CLEAR: sweeps x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer, colour BG_COLOUR, writeEn=1.
- DONE: done=1 and writeEn=0 for one cycle, then IDLE. busy falls in the same cycle done rises.
- Outputs are registered. The start accepted at edge 0 gives the first pixel at edge 1 and busy=1 from edge 1.
- Draw = 3*GLYPH_W*GLYPH_H pixel cycles (432 at defaults). Clear = SCREEN_W*SCREEN_H pixel cycles (19200).
- Outside pixel states, writeEn=0 and x_out/y_out/colour hold their last value.

Decomposition:
- Package note_glyph_pkg:
  - note code constants and state enum;
  - the 144-bit bitmaps A–G, SHARP and DIGIT1–DIGIT4;
  - a BLANK constant (all zero).
- Sub-module note_glyph_rom: combinational (note, octave) -> letter, sharp and oct bitmaps. Unknown codes map to BLANK.
- note_glyph_drawer instantiates the ROM and holds the FSM, counters and clipping.

Test Plan:
- Reset: assert resetn=0 mid-draw of A#/octave 2 at (10,20). All outputs are 0 at once. Release; with no start, no writeEn for 500 cycles.
- Draw A# (note=2), octave=1, at (10,20):
  - exactly 432 writes; first write at (10,20) is BG;
  - (12,21) is FG (sharp row 1, col 2); (27,21) is FG (letter A row 1, col 5);
  - done pulses 433 cycles after start, and busy is low the same cycle.
- Draw C (note=4) at (0,0): all 144 sharp-cell writes are BG_COLOUR; letter pixel (12+1, 1) is FG.
- Clipping: draw at x=150, y=115. No writeEn for any x >= 160 or y >= 120. done still arrives after 432 pixel cycles.
- Clear with start high in the same cycle: 19200 BG writes covering (0,0)..(159,119), no glyph writes, one done pulse.
- Start pulse while busy: ignored. Writes, end coordinates and done timing are identical to a single request; note=15 draws a fully BG letter cell.
